// File: rtl/fb_step_pkg.sv
// Shared mode encoding and wide-arithmetic helpers for the closed-loop step generator.
package fb_step_pkg;

  typedef enum logic [1:0] {
    FB_OFF    = 2'd0,
    FB_CLOSED = 2'd1,
    FB_CONST  = 2'd2,
    FB_HOLD   = 2'd3
  } fb_mode_e;

  localparam int FB_HW = 64;

  // Sign-extend the low w bits of v to the full helper width.
  function automatic logic signed [FB_HW-1:0] fb_sext(input logic [FB_HW-1:0] v, input int w);
    logic [FB_HW-1:0] t;
    t = v << (FB_HW - w);
    return $signed(t) >>> (FB_HW - w);
  endfunction

  function automatic logic signed [FB_HW-1:0] fb_clamp(input logic signed [FB_HW-1:0] v,
                                                       input logic signed [FB_HW-1:0] lim);
    logic signed [FB_HW-1:0] r;
    if (v > lim) begin
      r = lim;
    end else if (v < -lim) begin
      r = -lim;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/feedback_step_gen_mc_sat_add.sv
// Signed saturating adder: result pinned to the W-bit signed range, with an overflow flag.
module fb_sat_add #(
  parameter int W = 8
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic signed [W-1:0] o_sum,
  output logic                o_ovf
);

  logic [W:0] w_full;

  // One guard bit exposes overflow as a disagreement between the top two bits.
  always_comb begin
    w_full = {i_a[W-1], i_a} + {i_b[W-1], i_b};
    o_ovf  = w_full[W] ^ w_full[W-1];
    if (!o_ovf) begin
      o_sum = w_full[W-1:0];
    end else if (w_full[W]) begin
      o_sum = {1'b1, {(W-1){1'b0}}};
    end else begin
      o_sum = {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/feedback_step_gen_mc.sv
// Closed-loop feedback step generator: integrates demodulated error, scales by a right shift,
// clamps to +/-limit. Modes OFF/CLOSED/CONST/HOLD with bumpless gain and mode transitions.
module feedback_step_gen_mc
  import fb_step_pkg::*;
#(
  parameter int DW       = 32,
  parameter int ACCW     = 40,
  parameter int SHW      = 5,
  parameter int GAIN_RST = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_trig,
  input  logic signed [DW-1:0] i_err,
  input  logic [SHW-1:0]       i_gain_sel,
  input  logic [1:0]           i_mode,
  input  logic signed [DW-1:0] i_const_step,
  input  logic [DW-1:0]        i_step_lim,
  output logic signed [DW-1:0] o_step,
  output logic                 o_step_vld,
  output logic [1:0]           o_mode,
  output logic                 o_gain_chg,
  output logic                 o_acc_sat,
  output logic                 o_step_sat
);

  localparam int SW = ACCW + 1;
  localparam logic [SHW-1:0] GAIN_RST_V = GAIN_RST[SHW-1:0];

  logic                   r_trig1;
  logic signed [DW-1:0]   r_err1;
  logic [SHW-1:0]         r_gain1;
  fb_mode_e               r_mode1;

  fb_mode_e               r_mode;
  fb_mode_e               w_mode_nxt;
  logic [SHW-1:0]         r_gain;
  logic signed [ACCW-1:0] r_acc;
  logic signed [DW-1:0]   r_init;
  logic signed [DW-1:0]   r_step;
  logic                   r_vld;
  logic                   r_gchg;
  logic                   r_asat;
  logic                   r_ssat;

  logic                   w_gchg;
  logic                   w_rebase;
  logic signed [DW-1:0]   w_init_b;
  logic signed [ACCW-1:0] w_acc_b;
  logic signed [ACCW-1:0] w_err_x;
  logic signed [ACCW-1:0] w_acc_n;
  logic                   w_acc_ovf;
  logic signed [ACCW-1:0] w_shift;
  logic signed [SW-1:0]   w_init_x;
  logic signed [SW-1:0]   w_shift_x;
  logic signed [SW-1:0]   w_sum;
  logic                   w_sum_ovf;
  logic signed [63:0]     w_sum_cl;
  logic signed [63:0]     w_const_cl;
  logic                   w_sum_hit;
  logic                   w_const_hit;

  logic signed [DW-1:0]   w_step_nxt;
  logic signed [ACCW-1:0] w_acc_nxt;
  logic signed [DW-1:0]   w_init_nxt;
  logic                   w_vld_nxt;
  logic                   w_asat_nxt;
  logic                   w_ssat_nxt;

  // Input register stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_trig1 <= 1'b0;
      r_err1  <= '0;
      r_gain1 <= GAIN_RST_V;
      r_mode1 <= FB_OFF;
    end else begin
      r_trig1 <= i_trig;
      r_err1  <= i_err;
      r_gain1 <= i_gain_sel;
      r_mode1 <= fb_mode_e'(i_mode);
    end
  end

  // Mode state register: the applied mode.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode <= FB_OFF;
    end else begin
      r_mode <= w_mode_nxt;
    end
  end

  // Mode next-state: the applied mode follows the registered request every cycle.
  always_comb begin
    w_mode_nxt = r_mode;
    case (r_mode1)
      FB_OFF, FB_CLOSED, FB_CONST, FB_HOLD: w_mode_nxt = r_mode1;
      default:                              w_mode_nxt = FB_OFF;
    endcase
  end

  // Re-base decision and operand selection; a re-base restarts integration from the current step.
  always_comb begin
    w_gchg    = (r_gain1 != r_gain) && (r_mode1 != FB_OFF);
    w_rebase  = w_gchg || ((r_mode1 == FB_CLOSED) && ((r_mode == FB_CONST) || (r_mode == FB_HOLD)));
    w_init_b  = w_rebase ? r_step : r_init;
    w_acc_b   = w_rebase ? '0 : r_acc;
    w_err_x   = ACCW'(fb_sext(64'(r_err1), DW));
    w_shift   = w_acc_n >>> r_gain1;
    w_init_x  = SW'(w_init_b);
    w_shift_x = SW'(w_shift);
  end

  fb_sat_add #(.W(ACCW)) u_acc_add (
    .i_a   (w_acc_b),
    .i_b   (w_err_x),
    .o_sum (w_acc_n),
    .o_ovf (w_acc_ovf)
  );

  fb_sat_add #(.W(SW)) u_sum_add (
    .i_a   (w_init_x),
    .i_b   (w_shift_x),
    .o_sum (w_sum),
    .o_ovf (w_sum_ovf)
  );

  // Clamp candidates for the integrated step and the constant step.
  always_comb begin
    w_sum_cl    = fb_clamp(64'(w_sum), 64'(i_step_lim));
    w_const_cl  = fb_clamp(64'(i_const_step), 64'(i_step_lim));
    w_sum_hit   = (w_sum_cl != 64'(w_sum)) || w_sum_ovf;
    w_const_hit = (w_const_cl != 64'(i_const_step));
  end

  // Stage-2 next-state per requested mode.
  always_comb begin
    w_step_nxt = r_step;
    w_acc_nxt  = r_acc;
    w_init_nxt = r_init;
    w_vld_nxt  = 1'b0;
    w_asat_nxt = r_asat;
    w_ssat_nxt = r_ssat;
    case (r_mode1)
      FB_OFF: begin
        w_step_nxt = '0;
        w_acc_nxt  = '0;
        w_init_nxt = '0;
        w_asat_nxt = 1'b0;
        w_ssat_nxt = 1'b0;
      end
      FB_CLOSED: begin
        w_init_nxt = w_init_b;
        if (r_trig1) begin
          w_acc_nxt  = w_acc_n;
          w_step_nxt = DW'(w_sum_cl);
          w_vld_nxt  = 1'b1;
          w_ssat_nxt = w_sum_hit;
          w_asat_nxt = r_asat | w_acc_ovf;
        end else begin
          w_acc_nxt  = w_acc_b;
        end
      end
      FB_CONST: begin
        w_acc_nxt = '0;
        if (r_trig1) begin
          w_step_nxt = DW'(w_const_cl);
          w_init_nxt = DW'(w_const_cl);
          w_vld_nxt  = 1'b1;
          w_ssat_nxt = w_const_hit;
        end else begin
          w_init_nxt = r_step;
        end
      end
      FB_HOLD: begin
        w_acc_nxt  = w_acc_b;
        w_init_nxt = w_init_b;
      end
      default: begin
        w_step_nxt = '0;
        w_acc_nxt  = '0;
        w_init_nxt = '0;
      end
    endcase
  end

  // Stage-2 state and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gain <= GAIN_RST_V;
      r_acc  <= '0;
      r_init <= '0;
      r_step <= '0;
      r_vld  <= 1'b0;
      r_gchg <= 1'b0;
      r_asat <= 1'b0;
      r_ssat <= 1'b0;
    end else begin
      r_gain <= r_gain1;
      r_acc  <= w_acc_nxt;
      r_init <= w_init_nxt;
      r_step <= w_step_nxt;
      r_vld  <= w_vld_nxt;
      r_gchg <= w_gchg;
      r_asat <= w_asat_nxt;
      r_ssat <= w_ssat_nxt;
    end
  end

  assign o_step     = r_step;
  assign o_step_vld = r_vld;
  assign o_mode     = r_mode;
  assign o_gain_chg = r_gchg;
  assign o_acc_sat  = r_asat;
  assign o_step_sat = r_ssat;

endmodule

// File: tb/tb_feedback_step_gen_mc.sv
// Self-checking bench: behavioural model of the step generator compared every cycle,
// plus directed literal checks and a DW=ACCW=16 instance for accumulator saturation.
module tb_feedback_step_gen_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig = 1'b0;
  logic [31:0] err = 32'd0;
  logic [4:0]  gain = 5'd5;
  logic [1:0]  mode = 2'd0;
  logic [31:0] cst = 32'd0;
  logic [31:0] lim = 32'd10000;

  logic [31:0] o_step;
  logic        o_vld, o_gc, o_asat, o_ssat;
  logic [1:0]  o_mode;
  logic [15:0] s_step;
  logic        s_vld, s_gc, s_asat, s_ssat;
  logic [1:0]  s_mode;

  int n_cmp = 0;
  int n_fail = 0;

  localparam longint AMAX = 64'sd549755813887;
  localparam longint AMIN = -64'sd549755813888;

  longint m_step = 0, m_acc = 0, m_init = 0;
  int     m_gain = 5, m_mode = 0;
  bit     m_vld = 0, m_gc = 0, m_asat = 0, m_ssat = 0;
  bit     p_trig = 0;
  longint p_err = 0;
  int     p_gain = 5, p_mode = 0;

  feedback_step_gen_mc dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_trig(trig), .i_err(err), .i_gain_sel(gain),
    .i_mode(mode), .i_const_step(cst), .i_step_lim(lim),
    .o_step(o_step), .o_step_vld(o_vld), .o_mode(o_mode), .o_gain_chg(o_gc),
    .o_acc_sat(o_asat), .o_step_sat(o_ssat)
  );

  feedback_step_gen_mc #(.DW(16), .ACCW(16)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_trig(trig), .i_err(err[15:0]), .i_gain_sel(gain),
    .i_mode(mode), .i_const_step(cst[15:0]), .i_step_lim(lim[15:0]),
    .o_step(s_step), .o_step_vld(s_vld), .o_mode(s_mode), .o_gain_chg(s_gc),
    .o_acc_sat(s_asat), .o_step_sat(s_ssat)
  );

  initial forever #5 clk = ~clk;

  function automatic longint clampv(input longint v, input longint l);
    if (v > l) return l;
    if (v < -l) return -l;
    return v;
  endfunction

  task automatic model_reset();
    m_step = 0; m_acc = 0; m_init = 0; m_gain = 5; m_mode = 0;
    m_vld = 0; m_gc = 0; m_asat = 0; m_ssat = 0;
    p_trig = 0; p_err = 0; p_gain = 5; p_mode = 0;
  endtask

  // Applies the inputs captured one edge earlier, then captures the current inputs.
  task automatic model_tick();
    longint lv, s, c;
    bit gc;
    lv = longint'({32'd0, lim});
    gc = (p_gain != m_gain) && (p_mode != 0);
    m_vld = 0;
    m_gc = gc;
    if (p_mode == 0) begin
      m_step = 0; m_acc = 0; m_init = 0; m_asat = 0; m_ssat = 0;
    end else begin
      if (gc || (p_mode == 1 && m_mode >= 2)) begin
        m_init = m_step;
        m_acc = 0;
      end
      if (p_mode == 1 && p_trig) begin
        m_acc = m_acc + p_err;
        if (m_acc > AMAX) begin m_acc = AMAX; m_asat = 1; end
        if (m_acc < AMIN) begin m_acc = AMIN; m_asat = 1; end
        s = m_init + (m_acc >>> p_gain);
        c = clampv(s, lv);
        m_ssat = (c != s);
        m_step = c;
        m_vld = 1;
      end else if (p_mode == 2) begin
        m_acc = 0;
        if (p_trig) begin
          s = longint'($signed(cst));
          c = clampv(s, lv);
          m_ssat = (c != s);
          m_step = c;
          m_vld = 1;
        end
        m_init = m_step;
      end
    end
    m_gain = p_gain;
    m_mode = p_mode;
    p_trig = trig;
    p_err  = longint'($signed(err));
    p_gain = int'(gain);
    p_mode = int'(mode);
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else model_tick();
  end

  // Cycle-by-cycle comparison of the main instance against the model.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      n_cmp++;
      if (o_step !== m_step[31:0] || o_vld !== m_vld || o_mode !== m_mode[1:0] ||
          o_gc !== m_gc || o_asat !== m_asat || o_ssat !== m_ssat) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t step=%0d exp %0d vld=%0b exp %0b mode=%0d exp %0d gc=%0b exp %0b asat=%0b exp %0b ssat=%0b exp %0b",
                 $time, $signed(o_step), m_step, o_vld, m_vld, o_mode, m_mode, o_gc, m_gc,
                 o_asat, m_asat, o_ssat, m_ssat);
      end
    end
  end

  task automatic chk(input string nm, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic wait2();
    @(negedge clk);
    @(negedge clk);
  endtask

  // One-cycle trigger; returns at the negedge where the result must be visible.
  task automatic pulse(input logic [31:0] e);
    err = e;
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    chk("vld_early", longint'(o_vld), 0);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_step", longint'(o_step), 0);
    chk("rst_flags", longint'({o_vld, o_mode, o_gc, o_asat, o_ssat}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse(32'd100);
    chk("off_vld", longint'(o_vld), 0);
    chk("off_step", $signed(o_step), 0);

    gain = 5'd2; wait2();
    mode = 2'd1; wait2();
    pulse(32'd100); chk("cl1", $signed(o_step), 25); chk("cl1_model", m_step, 25);
    chk("cl1_vld", longint'(o_vld), 1);
    pulse(32'd100); chk("cl2", $signed(o_step), 50);
    pulse(32'd100); chk("cl3", $signed(o_step), 75); chk("cl3_model", m_step, 75);

    gain = 5'd4; wait2();
    chk("gchg_pulse", longint'(o_gc), 1); chk("gchg_step", $signed(o_step), 75);
    pulse(32'd32); chk("gchg_after", $signed(o_step), 77); chk("gchg_model", m_step, 77);

    mode = 2'd0; wait2(); chk("off_clear", $signed(o_step), 0);
    gain = 5'd0; lim = 32'd1000; wait2();
    mode = 2'd1; wait2();
    pulse(32'd600); chk("lim1", $signed(o_step), 600);
    pulse(32'd600); chk("lim2", $signed(o_step), 1000); chk("lim2_sat", longint'(o_ssat), 1);
    chk("lim2_model", m_step, 1000);

    mode = 2'd2; cst = -32'sd500; wait2();
    pulse(32'd0); chk("const", $signed(o_step), -500);
    mode = 2'd1; wait2();
    pulse(32'd0); chk("bumpless", $signed(o_step), -500); chk("bumpless_model", m_step, -500);
    mode = 2'd3; wait2();
    pulse(32'd5); chk("hold_vld", longint'(o_vld), 0); chk("hold_step", $signed(o_step), -500);
    mode = 2'd0; wait2(); chk("off_step2", $signed(o_step), 0);

    lim = 32'd32767; mode = 2'd1; wait2();
    pulse(32'd32767); chk("s_step1", $signed(s_step), 32767); chk("s_asat1", longint'(s_asat), 0);
    pulse(32'd32767); chk("s_asat2", longint'(s_asat), 1); chk("s_step2", $signed(s_step), 32767);
    chk("s_vld2", longint'(s_vld), 1); chk("s_ssat2", longint'(s_ssat), 0);
    pulse(32'hFFFF_FFFF); chk("s_asat_sticky", longint'(s_asat), 1); chk("s_step3", $signed(s_step), 32766);
    chk("s_mode", longint'(s_mode), 1); chk("s_gc", longint'(s_gc), 0);
    mode = 2'd0; wait2(); chk("s_asat_off", longint'(s_asat), 0);

    lim = 32'd10000; mode = 2'd1; wait2();
    pulse(32'd100); pulse(32'd100); chk("pre_arst", $signed(o_step), 200);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_step", longint'(o_step), 0);
    chk("arst_flags", longint'({o_vld, o_mode, o_gc, o_asat, o_ssat}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait2();
    pulse(32'd100); chk("arst_resume", $signed(o_step), 100);

    for (int seg = 0; seg < 4; seg++) begin
      if (seg >= 2) begin
        mode = 2'd1; gain = 5'd0; lim = 32'h7FFF_FFFF;
      end
      for (int i = 0; i < 1500; i++) begin
        @(negedge clk);
        trig = 1'($urandom_range(0, 1));
        if (seg == 0) err = $urandom_range(0, 4000) - 32'd2000;
        else if (seg == 1) err = $urandom();
        else if (seg == 2) err = 32'h7FFF_FFFF;
        else err = 32'h8000_0000;
        if (seg < 2) begin
          if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
          if ($urandom_range(0, 29) == 0) gain = 5'($urandom_range(0, 31));
          if ($urandom_range(0, 49) == 0) cst = $urandom();
        end
        if ($urandom_range(0, 59) == 0)
          lim = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 5000)) : ($urandom() >> 1);
      end
    end
    trig = 1'b0;
    wait2();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
